// File: rtl/sram_core.sv
// sram_core: synchronous single-port scratch RAM with a request FSM.
//   A request is accepted into READ/WRITE on one rising edge and performed on
//   the next edge for which the same request is still held.
// Ports:
//   clk            - system clock, rising edge
//   reset_n        - asynchronous active-low reset (state/data_out only)
//   chip_enable_n  - chip select, active-low
//   write_enable_n - write request, active-low
//   read_enable_n  - read request, active-low
//   address        - word address
//   data_in        - write data
//   data_out       - registered read data
module sram_core #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chip_enable_n,
  input  logic                  write_enable_n,
  input  logic                  read_enable_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    ERROR = 2'b11
  } state_e;

  state_e current_state;
  state_e req_d;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  // Zero-extend so the range check is an unsigned compare on a common width.
  logic [32:0] addr_ext;
  logic        addr_oob;
  assign addr_ext = {{(33-ADDR_WIDTH){1'b0}}, address};
  assign addr_oob = (addr_ext >= 33'(MEM_SIZE));

  always_comb begin
    req_d = IDLE;
    if (chip_enable_n)                          req_d = IDLE;
    else if (!write_enable_n && !read_enable_n) req_d = ERROR;
    else if (addr_oob)                          req_d = ERROR;
    else if (!write_enable_n)                   req_d = WRITE;
    else if (!read_enable_n)                    req_d = READ;
    else                                        req_d = IDLE;
  end

  // An access fires only when the held request matches the accepted state,
  // so any change of request (or abort) costs one access-free edge.
  logic do_write, do_read;
  assign do_write = (current_state == WRITE) && (req_d == WRITE);
  assign do_read  = (current_state == READ)  && (req_d == READ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      current_state <= IDLE;
      data_out      <= '0;
    end else begin
      current_state <= req_d;
      if (do_read) data_out <= mem[address];
    end
  end

  // Storage is never cleared; current_state is IDLE while in reset, so no
  // write can land during reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[address] <= data_in;
  end

endmodule

// File: tb/tb_sram_core.sv
module tb_sram_core;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       chip_enable_n;
  logic       write_enable_n;
  logic       read_enable_n;
  logic [7:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int vectors = 0;
  int errors  = 0;

  sram_core #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_SIZE(256)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .chip_enable_n (chip_enable_n),
    .write_enable_n(write_enable_n),
    .read_enable_n (read_enable_n),
    .address       (address),
    .data_in       (data_in),
    .data_out      (data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    chip_enable_n  = 1'b1;
    write_enable_n = 1'b1;
    read_enable_n  = 1'b1;
  endtask

  task automatic test_reset();
    idle_bus();
    address = 8'h00;
    data_in = 8'h00;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    vectors++;
    if (dut.current_state !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got %b want 00", dut.current_state);
    end
    vectors++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout: got %h want 00", data_out);
    end
  endtask

  task automatic test_write();
    chip_enable_n = 1'b0; write_enable_n = 1'b0; read_enable_n = 1'b1;
    address = 8'h00; data_in = 8'hAA;
    tick();
    vectors++;
    if (dut.current_state !== 2'b10) begin
      errors++;
      $display("FAIL write_entry_state: got %b want 10", dut.current_state);
    end
    tick();
    idle_bus();
    tick();
    vectors++;
    if (dut.mem[0] !== 8'hAA) begin
      errors++;
      $display("FAIL write_mem0: got %h want aa", dut.mem[0]);
    end
    vectors++;
    if (dut.current_state !== 2'b00) begin
      errors++;
      $display("FAIL write_idle_state: got %b want 00", dut.current_state);
    end
  endtask

  task automatic test_read();
    chip_enable_n = 1'b0; write_enable_n = 1'b1; read_enable_n = 1'b0;
    address = 8'h00;
    tick();
    vectors++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL read_entry_dout: got %h want 00", data_out);
    end
    tick();
    vectors++;
    if (data_out !== 8'hAA) begin
      errors++;
      $display("FAIL read_dout: got %h want aa", data_out);
    end
    idle_bus();
    tick();
    vectors++;
    if (data_out !== 8'hAA) begin
      errors++;
      $display("FAIL read_hold_dout: got %h want aa", data_out);
    end
  endtask

  task automatic test_burst();
    logic [7:0] addrs [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [7:0] datas [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    // 5-cycle write: entry edge then four access edges.
    chip_enable_n = 1'b0; write_enable_n = 1'b0; read_enable_n = 1'b1;
    address = addrs[0]; data_in = datas[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      address = addrs[i]; data_in = datas[i];
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dut.mem[addrs[i]] !== datas[i]) begin
        errors++;
        $display("FAIL burst_mem[%h]: got %h want %h", addrs[i], dut.mem[addrs[i]], datas[i]);
      end
    end
    // WRITE -> READ directly: one access-free entry edge.
    write_enable_n = 1'b1; read_enable_n = 1'b0;
    address = addrs[0];
    tick();
    vectors++;
    if (data_out !== 8'hAA) begin
      errors++;
      $display("FAIL burst_read_entry: got %h want aa", data_out);
    end
    for (int i = 0; i < 4; i++) begin
      address = addrs[i];
      tick();
      vectors++;
      if (data_out !== datas[i]) begin
        errors++;
        $display("FAIL burst_read[%0d]: got %h want %h", i, data_out, datas[i]);
      end
    end
    // Abort mid-read with a new address: no access on that edge.
    chip_enable_n = 1'b1; address = 8'h00;
    tick();
    vectors++;
    if (data_out !== 8'h44) begin
      errors++;
      $display("FAIL burst_abort_dout: got %h want 44", data_out);
    end
  endtask

  task automatic test_conflict();
    // Seed mem[5] with a known value first.
    chip_enable_n = 1'b0; write_enable_n = 1'b0; read_enable_n = 1'b1;
    address = 8'h05; data_in = 8'h77;
    tick();
    tick();
    idle_bus();
    tick();
    chip_enable_n = 1'b0; write_enable_n = 1'b0; read_enable_n = 1'b0;
    address = 8'h05; data_in = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (dut.current_state !== 2'b11) begin
        errors++;
        $display("FAIL conflict_state[%0d]: got %b want 11", i, dut.current_state);
      end
    end
    vectors++;
    if (dut.mem[5] !== 8'h77) begin
      errors++;
      $display("FAIL conflict_mem5: got %h want 77", dut.mem[5]);
    end
    vectors++;
    if (data_out !== 8'h44) begin
      errors++;
      $display("FAIL conflict_dout: got %h want 44", data_out);
    end
    write_enable_n = 1'b1; read_enable_n = 1'b1;
    tick();
    vectors++;
    if (dut.current_state !== 2'b00) begin
      errors++;
      $display("FAIL conflict_release_state: got %b want 00", dut.current_state);
    end
    idle_bus();
  endtask

  task automatic test_async_reset();
    // Seed target word, then start a write of a different value.
    chip_enable_n = 1'b0; write_enable_n = 1'b0; read_enable_n = 1'b1;
    address = 8'h20; data_in = 8'h12;
    tick();
    tick();
    idle_bus();
    tick();
    chip_enable_n = 1'b0; write_enable_n = 1'b0;
    address = 8'h20; data_in = 8'h99;
    tick();
    vectors++;
    if (dut.current_state !== 2'b10) begin
      errors++;
      $display("FAIL arst_pre_state: got %b want 10", dut.current_state);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (dut.current_state !== 2'b00) begin
      errors++;
      $display("FAIL arst_state: got %b want 00", dut.current_state);
    end
    vectors++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL arst_dout: got %h want 00", data_out);
    end
    tick();
    idle_bus();
    reset_n = 1'b1;
    tick();
    vectors++;
    if (dut.mem[8'h20] !== 8'h12) begin
      errors++;
      $display("FAIL arst_mem20: got %h want 12", dut.mem[8'h20]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_burst();
    test_conflict();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
